ula_arbiter: RTL

ULA_ARBITER -- requirements
Module: ula_arbiter

---
 rtl/ula_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/ula_arbiter.sv
// Two-requester round-robin front end for an external combinational ULA.
// Optional opcode legality check is enabled with ULA_ARBITER_OPCHECK_EN.
module ula_arbiter #(
   parameter logic LAST_INIT = 1'b1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [3:0]  req0_op,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [3:0]  req1_op,
   output logic [31:0] ula_a,
   output logic [31:0] ula_b,
   output logic [3:0]  ula_op,
   input  logic [31:0] ula_s,
   input  logic        ula_z,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic        resp_id,
   output logic [31:0] resp_s,
   output logic        resp_z,
   output logic        resp_err
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  op;
   } ula_req_t;

   state_t   state, state_nxt;
   logic     last;
   logic     gnt0, gnt1, accept;
   ula_req_t sel;

   // On contention the requester that did not win last time goes first.
   always_comb begin
      gnt0 = req0_valid & (~req1_valid | last);
      gnt1 = req1_valid & (~req0_valid | ~last);
      sel  = gnt1 ? ula_req_t'{req1_a, req1_b, req1_op}
                  : ula_req_t'{req0_a, req0_b, req0_op};
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      resp_valid = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            req0_ready = gnt0;
            req1_ready = gnt1;
            accept     = gnt0 | gnt1;
            if (accept) state_nxt = EXEC;
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         ula_a   <= '0;
         ula_b   <= '0;
         ula_op  <= '0;
         resp_id <= 1'b0;
         last    <= LAST_INIT;
         resp_s  <= '0;
         resp_z  <= 1'b0;
      end else begin
         if (accept) begin
            ula_a   <= sel.a;
            ula_b   <= sel.b;
            ula_op  <= sel.op;
            resp_id <= gnt1;
            last    <= gnt1;
         end
         // ULA result settles during EXEC from the registered operands.
         if (state == EXEC) begin
            resp_s <= ula_s;
            resp_z <= ula_z;
         end
      end
   end

`ifdef ULA_ARBITER_OPCHECK_EN
   function automatic logic op_illegal(input logic [3:0] op);
      case (op)
         4'b0000, 4'b0001, 4'b0010, 4'b0110,
         4'b0111, 4'b1000, 4'b1100: return 1'b0;
         default:                   return 1'b1;
      endcase
   endfunction

   logic err_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)       err_q <= 1'b0;
      else if (accept) err_q <= op_illegal(sel.op);
   end

   assign resp_err = err_q;
`else
   assign resp_err = 1'b0;
`endif

endmodule
